// File: rtl/alu_req_scheduler_pkg.sv
// alu_sched_pkg
// Shared types and constants for the ALU request scheduler:
//   - state_t : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   - FUNC_W / OP_W : function-code and opcode widths
//   - FC_OPn / OPC_n : the eight legal one-hot function codes and their opcodes
package alu_sched_pkg;

   localparam int FUNC_W = 8;
   localparam int OP_W   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Legal function codes: all-zero plus the one-hot codes above bit 0.
   localparam logic [FUNC_W-1:0] FC_OP0 = 8'h00;
   localparam logic [FUNC_W-1:0] FC_OP1 = 8'h02;
   localparam logic [FUNC_W-1:0] FC_OP2 = 8'h04;
   localparam logic [FUNC_W-1:0] FC_OP3 = 8'h08;
   localparam logic [FUNC_W-1:0] FC_OP4 = 8'h10;
   localparam logic [FUNC_W-1:0] FC_OP5 = 8'h20;
   localparam logic [FUNC_W-1:0] FC_OP6 = 8'h40;
   localparam logic [FUNC_W-1:0] FC_OP7 = 8'h80;

   localparam logic [OP_W-1:0] OPC_0 = 3'd0;
   localparam logic [OP_W-1:0] OPC_1 = 3'd1;
   localparam logic [OP_W-1:0] OPC_2 = 3'd2;
   localparam logic [OP_W-1:0] OPC_3 = 3'd3;
   localparam logic [OP_W-1:0] OPC_4 = 3'd4;
   localparam logic [OP_W-1:0] OPC_5 = 3'd5;
   localparam logic [OP_W-1:0] OPC_6 = 3'd6;
   localparam logic [OP_W-1:0] OPC_7 = 3'd7;

endpackage

// File: rtl/alu_req_scheduler_if.sv
// alu_req_scheduler_if
// Bundles the requester side and the ALU side of the scheduler.
//   req, func_code, opa, opb : per-requester request level, code, operands
//   gnt, rsp_valid, rsp_data : grant and response back to requesters
//   alu_op, alu_a, alu_b, alu_start, alu_result : ALU handshake
//   illegal, busy            : status
// Modports: slave = the scheduler, master = requesters plus ALU.
interface alu_req_scheduler_if
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);

   logic [NUM_REQ-1:0]        req;
   logic [FUNC_W*NUM_REQ-1:0] func_code;
   logic [DATA_W*NUM_REQ-1:0] opa;
   logic [DATA_W*NUM_REQ-1:0] opb;
   logic [NUM_REQ-1:0]        gnt;
   logic [OP_W-1:0]           alu_op;
   logic [DATA_W-1:0]         alu_a;
   logic [DATA_W-1:0]         alu_b;
   logic                      alu_start;
   logic [DATA_W-1:0]         alu_result;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      illegal;
   logic                      busy;

   modport slave (
      input  req, func_code, opa, opb, alu_result,
      output gnt, alu_op, alu_a, alu_b, alu_start, rsp_valid, rsp_data, illegal, busy
   );

   modport master (
      output req, func_code, opa, opb, alu_result,
      input  gnt, alu_op, alu_a, alu_b, alu_start, rsp_valid, rsp_data, illegal, busy
   );

endinterface

// File: rtl/alu_req_scheduler_funccode_enc.sv
// funccode_enc
// Combinational encoder from an 8-bit function code to the 3-bit ALU opcode.
//   func_code : in  8-bit code (legal: 0x00 or one-hot above bit 0)
//   opcode    : out encoded opcode, 0 for anything illegal
//   illegal   : out high when func_code is not one of the eight legal codes
module funccode_enc
   import alu_sched_pkg::*;
(
   input  logic [FUNC_W-1:0] func_code,
   output logic [OP_W-1:0]   opcode,
   output logic              illegal
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      opcode  = OPC_0;
      illegal = 1'b0;
      case (func_code)
         FC_OP0:  opcode = OPC_0;
         FC_OP1:  opcode = OPC_1;
         FC_OP2:  opcode = OPC_2;
         FC_OP3:  opcode = OPC_3;
         FC_OP4:  opcode = OPC_4;
         FC_OP5:  opcode = OPC_5;
         FC_OP6:  opcode = OPC_6;
         FC_OP7:  opcode = OPC_7;
         default: illegal = 1'b1;   // 0x01 and multi-bit codes run as opcode 0
      endcase
   end

endmodule

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler
// Shares one ALU between NUM_REQ requesters with round-robin arbitration.
// One transaction: IDLE (arbitrate) -> ISSUE (alu_start) -> WAIT (ALU_LAT
// cycles) -> RESP (rsp_valid pulse) -> IDLE. All outputs are registered.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_req_scheduler_if.slave (requester and ALU signals)
module alu_req_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ALU_LAT = 1
)
(
   input  logic               clk,
   input  logic               rst_n,
   alu_req_scheduler_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(ALU_LAT + 1);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   winner;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   pick;
   logic [FUNC_W-1:0]  win_code;
   logic [OP_W-1:0]    enc_op;
   logic               enc_illegal;

   // First set req bit found scanning upward from p, wrapping at NUM_REQ.
   // Scanning k downward lets the smallest offset overwrite the result last.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
      logic [IDX_W-1:0] w;
      int               idx;
      w = p;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(p) + k) % NUM_REQ;
         if (r[IDX_W'(idx)]) w = IDX_W'(idx);
      end
      return w;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [NUM_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   assign pick     = rr_pick(bus.req, ptr);
   assign win_code = bus.func_code[FUNC_W*pick +: FUNC_W];

   funccode_enc u_enc (
      .func_code (win_code),
      .opcode    (enc_op),
      .illegal   (enc_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         winner        <= '0;
         cnt           <= '0;
         bus.gnt       <= '0;
         bus.alu_op    <= '0;
         bus.alu_a     <= '0;
         bus.alu_b     <= '0;
         bus.alu_start <= 1'b0;
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
         bus.illegal   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         // Single-cycle pulses default low; the state that raises them overrides.
         bus.alu_start <= 1'b0;
         bus.illegal   <= 1'b0;
         bus.rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  // Everything the transaction needs is captured here, so the
                  // requester may drop req or change operands afterwards.
                  winner        <= pick;
                  bus.gnt       <= onehot(pick);
                  bus.alu_op    <= enc_op;
                  bus.illegal   <= enc_illegal;
                  bus.alu_a     <= bus.opa[DATA_W*pick +: DATA_W];
                  bus.alu_b     <= bus.opb[DATA_W*pick +: DATA_W];
                  bus.alu_start <= 1'b1;
                  bus.busy      <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= CNT_W'(ALU_LAT);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  bus.rsp_data  <= bus.alu_result;
                  bus.rsp_valid <= onehot(winner);
                  state         <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               // Winner drops to lowest priority for the next arbitration.
               ptr      <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
               bus.gnt  <= '0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Shares one ALU between NUM_REQ requesters with a round-robin arbiter. Each requester presents an 8-bit one-hot function code and two operands. The block grants one request at a time, encodes the function code to the 3-bit ALU opcode, and issues a single-cycle start. It waits a fixed ALU latency, captures the result and returns it to the granted requester with a one-cycle valid pulse. It sits between the instruction-issue stage and the ALU in the lab processor datapath.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- DATA_W, 8: operand/result width.
- ALU_LAT, 1: cycles from alu_start to valid alu_result; ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- func_code  in  8*NUM_REQ  function code of requester i at bits [8i+7:8i].
- opa, opb  in  DATA_W*NUM_REQ  operands of requester i at [DATA_W*i +: DATA_W].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- alu_op  out  3  encoded opcode.
- alu_a, alu_b  out  DATA_W  latched operands.
- alu_start  out  1  one-cycle ALU start.
- alu_result  in  DATA_W  ALU result.
- rsp_valid  out  NUM_REQ  one-hot response pulse.
- rsp_data  out  DATA_W  returned result, valid with rsp_valid.
- illegal  out  1  pulses with alu_start when the granted code is not legal.
- busy  out  1  high in any state other than IDLE.

## Operation
- Legal codes map as follows: 0x00→0, 0x02→1, 0x04→2, 0x08→3, 0x10→4, 0x20→5, 0x40→6, 0x80→7.
- Any other code, including 0x01 and multi-bit codes, maps to opcode 0 and sets illegal. The operation still executes and the response is still returned.
- State IDLE: if any req bit is set, pick the winner by scanning from ptr upward, modulo NUM_REQ.
  - Latch the winner index, encoded opcode, illegal flag, opa and opb.
  - Go to ISSUE.
- State ISSUE: alu_start=1, illegal=latched flag. Load wait counter with ALU_LAT. Go to WAIT.
- State WAIT: decrement the counter each cycle.
  - On the cycle the counter reads 1, register alu_result into rsp_data.
  - Go to RESP.
- State RESP: rsp_valid[winner]=1. Set ptr=(winner+1) mod NUM_REQ. Go to IDLE.
- gnt[winner] is high in ISSUE, WAIT and RESP. alu_op, alu_a and alu_b are held stable for the same span.
- Operands are latched at grant. A req drop or data change after grant is ignored and the transaction completes.
- A requester that keeps req high after its rsp_valid re-enters arbitration at lowest priority.
- Reset values: state=IDLE, ptr=0. gnt, alu_op, alu_a, alu_b, alu_start, rsp_valid, rsp_data, illegal and busy are all 0.
- Reset mid-transaction aborts it: no rsp_valid is produced, and ptr returns to 0.

## Timing
- req is sampled in IDLE at cycle T.
- Cycle T+1 (ISSUE): gnt, alu_start, alu_op and alu_a/alu_b are valid.
- Cycles T+2 .. T+1+ALU_LAT (WAIT): alu_result is sampled at the end of cycle T+1+ALU_LAT.
- Cycle T+2+ALU_LAT (RESP): rsp_valid and rsp_data are valid.
- Cycle T+3+ALU_LAT: back in IDLE, where the next arbitration is sampled.
- Throughput is one operation per ALU_LAT+3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package alu_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - localparams for the eight legal function codes and their opcodes;
  - the opcode width (3) and function-code width (8).
- Sub-module funccode_enc: a combinational 8-bit to {3-bit opcode, illegal} encoder, instantiated once on the muxed winner code.
- The round-robin priority pick stays inline as a function.

## Test plan
- Single request, ALU_LAT=1: req=0001, func_code[0]=0x08, opa=5, opb=3, ALU model returns a+b=8.
  - gnt=0001 and alu_start at T+1 with alu_op=3.
  - rsp_valid=0001 and rsp_data=8 at T+3.
  - busy low at T+4.
- Round robin: req=1111 held continuously.
  - Grants appear in order 0001, 0010, 0100, 1000, 0001.
  - No requester is granted twice before all others have been served.
- Illegal code: func_code[2]=0x01, then 0x0C.
  - Each gives alu_op=0 with illegal high during ISSUE only.
  - rsp_valid[2] is still returned.
- Latency: ALU_LAT=3, single request at T.
  - alu_start at T+1, then 3 WAIT cycles.
  - alu_result is sampled at the end of T+4, and rsp_valid occurs at T+5.
- Request drop: deassert req[1] and change opa[1] in the cycle after grant.
  - alu_a keeps the value latched at grant.
  - rsp_valid[1] is still produced.
- Reset during WAIT: pull rst_n low asynchronously.
  - All outputs go to 0 immediately and no rsp_valid appears.
  - After release with req=0110, the first grant is 0010 because ptr=0.
